// File: rtl/dmem_responder_if.sv
// CPU data-memory request/response bus between a load/store unit (master)
// and a memory responder (slave).
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Single-request data-memory responder with programmable wait states.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned requests with resp_err.
module dmem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_STATES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   dmem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);

   if (DEPTH_WORDS < 2 || DEPTH_WORDS > 1024 ||
       (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("DEPTH_WORDS must be a power of two in 2..1024");
   end
   if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
      $error("WAIT_STATES must be in 0..15");
   end

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state, state_nxt;
   logic [3:0]      cnt, cnt_nxt;
   logic            accept, access;

   logic            write_q;
   logic [AW-1:0]   idx_q;
   logic [31:0]     wdata_q;
   logic            misal_q;
   logic            misal_in;
   logic [31:0]     rdata_q;
   logic            err_q;

   logic [31:0]     mem [DEPTH_WORDS];

`ifdef DMEM_ALIGN_CHECK_EN
   assign misal_in = |bus.req_addr[1:0];
   logic unused_addr;
   assign unused_addr = ^bus.req_addr[31:AW+2];
`else
   assign misal_in = 1'b0;
   logic unused_addr;
   assign unused_addr = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      accept         = 1'b0;
      access         = 1'b0;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               accept    = 1'b1;
               cnt_nxt   = 4'(WAIT_STATES);
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnt != 4'd0) begin
               cnt_nxt = cnt - 4'd1;
            end else begin
               access    = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         misal_q <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            write_q <= bus.req_write;
            idx_q   <= bus.req_addr[AW+1:2];
            wdata_q <= bus.req_wdata;
            misal_q <= misal_in;
         end
         // Response fields are only written at the access edge, so they
         // hold stable for the whole RESP phase.
         if (access) begin
            err_q   <= misal_q;
            rdata_q <= (write_q || misal_q) ? 32'd0 : mem[idx_q];
         end
      end
   end

   // Storage is deliberately not reset; access is never high in reset since
   // the state register is already forced to IDLE.
   always_ff @(posedge clk) begin
      if (access && write_q && !misal_q) mem[idx_q] <= wdata_q;
   end

   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: word-addressed storage depth, power of two, 2 to 1024.
REQ-002 Parameter WAIT_STATES, default 2: extra access cycles per request, 0 to 15.
REQ-003 Port clk  input  1: single clock; all state changes on rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port req_valid  input  1: CPU load/store request present.
REQ-006 Port req_ready  output  1: responder can accept a request this cycle.
REQ-007 Port req_write  input  1: 1 = store, 0 = load.
REQ-008 Port req_addr  input  32: byte address.
REQ-009 Port req_wdata  input  32: store data.
REQ-010 Port resp_valid  output  1: response present.
REQ-011 Port resp_ready  input  1: CPU accepts the response.
REQ-012 Port resp_rdata  output  32: load data; 0 on store responses.
REQ-013 Port resp_err  output  1: request rejected (see Configuration).

Function
REQ-014 FSM states: IDLE, WAIT, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; req_* inputs SHALL be ignored in WAIT and RESP.
REQ-016 Accept on req_valid && req_ready: latch write, addr, wdata; counter loaded with WAIT_STATES; go to WAIT.
REQ-017 In WAIT with counter != 0: decrement counter, stay in WAIT.
REQ-018 In WAIT with counter == 0: perform the access at that edge, register resp_rdata and resp_err, go to RESP.
REQ-019 resp_valid SHALL first be 1 exactly WAIT_STATES+1 rising edges after the accepting edge.
REQ-020 Word index = req_addr[log2(DEPTH_WORDS)+1:2]; upper address bits ignored (addresses wrap modulo DEPTH_WORDS*4).
REQ-021 Store: memory word at index updated at the access edge; resp_rdata = 0.
REQ-022 Load: resp_rdata = word at index as of the access edge.
REQ-023 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_valid && resp_ready.
REQ-024 On response handshake: go to IDLE, resp_valid = 0 next cycle; req_ready = 1 from the next cycle (no same-cycle re-accept).
REQ-025 Minimum request-to-request period: WAIT_STATES+3 cycles with resp_ready tied high.
REQ-026 Storage contents are not reset; a load from a never-written word returns an undefined value.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, counter 0, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0.
REQ-028 Reset in WAIT before the access edge SHALL discard the request; no memory update occurs.
REQ-029 Reset in RESP SHALL drop the response; a store already performed remains in memory.
REQ-030 Deassertion of rst_n SHALL take effect only on a later rising edge (first accept no earlier than the first edge with rst_n high).

Configuration
REQ-031 Macro DMEM_ALIGN_CHECK_EN defined: request with req_addr[1:0] != 0 SHALL not modify memory, and its response SHALL carry resp_err = 1, resp_rdata = 0, with normal latency.
REQ-032 DMEM_ALIGN_CHECK_EN undefined: req_addr[1:0] ignored, resp_err tied to 0.

Verification
REQ-033 WAIT_STATES=2: store 0xDEADBEEF at 0x10, resp_ready=1 -> resp_valid high 3 edges after accept, resp_rdata=0; load 0x10 -> resp_rdata=0xDEADBEEF.
REQ-034 Hold resp_ready=0 for 5 cycles after load of 0x10 -> resp_valid and resp_rdata=0xDEADBEEF stable all 5 cycles, req_ready=0 throughout; release -> IDLE next cycle.
REQ-035 DEPTH_WORDS=64: store 0x12345678 at 0x104 -> load 0x004 returns 0x12345678 (wrap).
REQ-036 Store 0xAAAA5555 at 0x20, assert rst_n=0 during WAIT -> resp_valid=0 immediately; subsequent load 0x20 does not return 0xAAAA5555 (after prior store of 0 there, returns 0).
REQ-037 With DMEM_ALIGN_CHECK_EN: store 0xFFFFFFFF at 0x22 -> resp_err=1, resp_rdata=0; load 0x20 returns prior value; without macro same store writes word 0x20 and resp_err=0.
REQ-038 WAIT_STATES=0: load accepted at edge N -> resp_valid high after edge N+1; req_valid held high during WAIT/RESP -> exactly one accept.
